// File: rtl/ifetch_pkg.sv
// Shared state encoding and reset constants for the instruction-fetch stage.
package ifetch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_DONE = 2'd2;
    localparam state_t ST_ERR  = 2'd3;

    localparam logic [31:0] IFETCH_RESET_ADDR = 32'h0000_3000;
    localparam logic [31:0] IFETCH_NOP        = 32'h0000_0000;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// 8-bit wait-cycle counter; tc_o flags the last permitted cycle without an ack.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [7:0] TC_VALUE = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign tc_o = (count_q == TC_VALUE);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: req/ack fetch of pc_addr into an instruction register.
// Optional macro IFETCH_ALIGN_CHECK_EN turns misaligned fetch_start into a fetch error.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned           WIDTH          = 32,
    parameter logic [WIDTH-1:0]      RESET_ADDR     = WIDTH'(IFETCH_RESET_ADDR),
    parameter logic [31:0]           RESET_INSTR    = IFETCH_NOP,
    parameter int unsigned           TIMEOUT_CYCLES = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_addr,
    input  logic             fetch_start,
    input  logic             flush,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    output logic             busy,
    output logic             fetch_err
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [31:0]      instr_q, instr_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic timer_clr;
    logic timer_en;
    logic timer_tc;
    logic misaligned;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign misaligned = (pc_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr_i (timer_clr),
        .en_i  (timer_en),
        .tc_o  (timer_tc)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        err_d     = err_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            valid_d = 1'b0;
            err_d   = 1'b0;
            instr_d = RESET_INSTR;
        end else if (state_q == ST_WAIT) begin
            // ack on the terminal-count cycle still completes the fetch
            if (imem_ack) begin
                instr_d = imem_rdata;
                pc_d    = addr_q;
                valid_d = 1'b1;
                req_d   = 1'b0;
                state_d = ST_DONE;
            end else if (timer_tc) begin
                req_d   = 1'b0;
                err_d   = 1'b1;
                state_d = ST_ERR;
            end else begin
                timer_en = 1'b1;
            end
        end else if (fetch_start) begin
            valid_d = 1'b0;
            if (misaligned) begin
                state_d = ST_ERR;
                err_d   = 1'b1;
                pc_d    = pc_addr;
            end else begin
                state_d   = ST_WAIT;
                req_d     = 1'b1;
                addr_d    = pc_addr & ALIGN_MASK;
                err_d     = 1'b0;
                timer_clr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= RESET_ADDR;
            instr_q <= RESET_INSTR;
            pc_q    <= RESET_ADDR;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_pc    = pc_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;
    assign busy        = (state_q == ST_WAIT);

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vector table, corner sequences, random fetches.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_addr = '0;
    logic        fetch_start = 1'b0;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        busy;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    // Architectural view of the instruction register as the bench expects it
    logic [31:0] model_instr = 32'h0000_0000;
    logic [31:0] model_pc    = 32'h0000_3000;

    ifetch_unit #(
        .WIDTH          (32),
        .RESET_ADDR     (32'h0000_3000),
        .RESET_INSTR    (32'h0000_0000),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_addr     (pc_addr),
        .fetch_start (fetch_start),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .busy        (busy),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle (1-based after start) in which WAIT ends: ack, flush or the 15th wait cycle
    function automatic int term_of(input int ack_cyc, input int flush_cyc);
        int t;
        t = 15;
        if (ack_cyc >= 1 && ack_cyc < t) t = ack_cyc;
        if (flush_cyc >= 1 && flush_cyc < t) t = flush_cyc;
        return t;
    endfunction

    // outcome codes: 0 flushed, 1 success, 2 timeout
    task automatic run_txn(input logic [31:0] pc, input int ack_cyc, input logic [31:0] rdata,
                           input int flush_cyc, input int restart_cyc);
        int          term;
        int          outcome;
        bit          in_wait;
        bit          late_flush;
        logic [31:0] apc;
        apc  = pc & 32'hFFFF_FFFC;
        term = term_of(ack_cyc, flush_cyc);
        if (flush_cyc == term)    outcome = 0;
        else if (ack_cyc == term) outcome = 1;
        else                      outcome = 2;

        pc_addr = pc; fetch_start = 1'b1; flush = 1'b0; imem_ack = 1'b0;
        step();
        fetch_start = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            in_wait    = (c <= term);
            late_flush = (flush_cyc > term) && (c > flush_cyc);
            check("imem_req", {31'b0, imem_req}, {31'b0, in_wait});
            check("busy", {31'b0, busy}, {31'b0, in_wait});
            if (in_wait) check("imem_addr", imem_addr, apc);
            check("instr_valid", {31'b0, instr_valid},
                  {31'b0, (!in_wait && outcome == 1 && !late_flush)});
            check("fetch_err", {31'b0, fetch_err},
                  {31'b0, (!in_wait && outcome == 2 && !late_flush)});
            if (c < 19) begin
                imem_ack    = (c == ack_cyc);
                imem_rdata  = (c == ack_cyc) ? rdata : $urandom;
                flush       = (c == flush_cyc);
                fetch_start = (c == restart_cyc);
                pc_addr     = (c == restart_cyc) ? pc + 32'h100 : pc;
                step();
            end
        end
        imem_ack = 1'b0; flush = 1'b0; fetch_start = 1'b0;

        if (outcome == 0) model_instr = 32'h0;
        if (outcome == 1) begin
            model_instr = rdata;
            model_pc    = apc;
        end
        if (flush_cyc > term && flush_cyc <= 18) model_instr = 32'h0;
        check("instr", instr, model_instr);
        check("instr_pc", instr_pc, model_pc);
    endtask

    typedef struct {
        logic [31:0] pc;
        int          ack_cyc;
        logic [31:0] rdata;
        int          flush_cyc;
        int          restart_cyc;
        logic        exp_valid;
        logic        exp_err;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h3004,  1, 32'h2408_0005, 0, 0, 1'b1, 1'b0, 32'h2408_0005, 32'h3004};
        vecs[1] = '{32'h3010,  6, 32'h8C09_0004, 0, 3, 1'b1, 1'b0, 32'h8C09_0004, 32'h3010};
        vecs[2] = '{32'h3020,  0, 32'h0000_0000, 0, 0, 1'b0, 1'b1, 32'h8C09_0004, 32'h3010};
        vecs[3] = '{32'h3024, 15, 32'hAAAA_5555, 0, 0, 1'b1, 1'b0, 32'hAAAA_5555, 32'h3024};
        vecs[4] = '{32'h3028, 16, 32'h5555_AAAA, 0, 0, 1'b0, 1'b1, 32'hAAAA_5555, 32'h3024};
        vecs[5] = '{32'h302C,  4, 32'h1234_5678, 4, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h3024};
        vecs[6] = '{32'h3008,  2, 32'h0123_4567, 0, 0, 1'b1, 1'b0, 32'h0123_4567, 32'h3008};
        vecs[7] = '{32'h3030,  3, 32'h0BAD_F00D, 9, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h3030};
        vecs[8] = '{32'h3040,  0, 32'h0000_0000, 16, 0, 1'b0, 1'b0, 32'h0000_0000, 32'h3030};

        #12;
        check("reset imem_req", {31'b0, imem_req}, 32'h0);
        check("reset imem_addr", imem_addr, 32'h3000);
        check("reset instr_pc", instr_pc, 32'h3000);
        rst = 1'b0;
        step();
        check("idle imem_req", {31'b0, imem_req}, 32'h0);
        check("idle imem_addr", imem_addr, 32'h3000);
        check("idle instr_pc", instr_pc, 32'h3000);
        check("idle instr", instr, 32'h0);
        check("idle instr_valid", {31'b0, instr_valid}, 32'h0);
        check("idle fetch_err", {31'b0, fetch_err}, 32'h0);
        check("idle busy", {31'b0, busy}, 32'h0);

        foreach (vecs[i]) begin
            run_txn(vecs[i].pc, vecs[i].ack_cyc, vecs[i].rdata, vecs[i].flush_cyc, vecs[i].restart_cyc);
            check("vec valid", {31'b0, instr_valid}, {31'b0, vecs[i].exp_valid});
            check("vec err", {31'b0, fetch_err}, {31'b0, vecs[i].exp_err});
            check("vec instr", instr, vecs[i].exp_instr);
            check("vec instr_pc", instr_pc, vecs[i].exp_pc);
        end

`ifdef IFETCH_ALIGN_CHECK_EN
        pc_addr = 32'h3006; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        check("misalign imem_req", {31'b0, imem_req}, 32'h0);
        check("misalign fetch_err", {31'b0, fetch_err}, 32'h1);
        check("misalign instr_pc", instr_pc, 32'h3006);
        check("misalign instr_valid", {31'b0, instr_valid}, 32'h0);
        step();
        check("misalign imem_req hold", {31'b0, imem_req}, 32'h0);
        model_pc = 32'h3006;
`else
        run_txn(32'h3006, 2, 32'h1111_1111, 0, 0);
        check("misalign truncated pc", instr_pc, 32'h3004);
`endif

        // Reset in the middle of WAIT drops the request without latching data
        pc_addr = 32'h3050; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        step(); step();
        rst = 1'b1;
        #1;
        check("midwait rst imem_req", {31'b0, imem_req}, 32'h0);
        check("midwait rst busy", {31'b0, busy}, 32'h0);
        check("midwait rst imem_addr", imem_addr, 32'h3000);
        rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        check("stray ack valid", {31'b0, instr_valid}, 32'h0);
        check("stray ack instr", instr, 32'h0);
        check("stray ack instr_pc", instr_pc, 32'h3000);
        model_instr = 32'h0;
        model_pc    = 32'h3000;

        for (int n = 0; n < 40; n++) begin
            logic [31:0] rpc;
            int          a;
            int          f;
            int          r;
            int          t;
            rpc = 32'h3000 + ($urandom_range(0, 255) << 2);
            a   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 17));
            f   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 18)) : 0;
            t   = term_of(a, f);
            r   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, t)) : 0;
            run_txn(rpc, a, $urandom, f, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program counter register.
- Takes the current PC address and, on a start pulse from the multi-cycle control FSM, issues a request to instruction memory. The memory uses a req/ack handshake with variable latency.
- Latches the returned word into an instruction register with the PC it came from. Signals completion or bus timeout to the control FSM.

Parameters:
- WIDTH, 32, address width.
- RESET_ADDR, 32'h0000_3000, reset value of imem_addr and instr_pc; matches the PC reset vector.
- RESET_INSTR, 32'h0000_0000, reset/flush value of instr (MIPS NOP).
- TIMEOUT_CYCLES, 15, maximum WAIT cycles without ack before a fetch error; range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_addr  in  WIDTH  current PC value.
- fetch_start  in  1  single-cycle pulse requesting a fetch of pc_addr.
- flush  in  1  abort or clear the fetch stage.
- imem_req  out  1  request to instruction memory; registered.
- imem_addr  out  WIDTH  fetch address; registered, stable while imem_req=1.
- imem_ack  in  1  memory has placed data on imem_rdata this cycle.
- imem_rdata  in  32  instruction word from memory.
- instr  out  32  instruction register.
- instr_pc  out  WIDTH  address instr was fetched from.
- instr_valid  out  1  instr holds a completed fetch.
- busy  out  1  high in WAIT.
- fetch_err  out  1  last fetch failed.

Behaviour:
- Reset: asynchronous, active-high. Values:
  - state=IDLE
  - imem_req=0, imem_addr=RESET_ADDR
  - instr=RESET_INSTR, instr_pc=RESET_ADDR
  - instr_valid=0, fetch_err=0, timer=0
- FSM states: IDLE, WAIT, DONE, ERR.
- IDLE, DONE or ERR with fetch_start=1 and flush=0:
  - imem_addr<=pc_addr, imem_req<=1, timer<=0
  - instr_valid<=0, fetch_err<=0
  - next state WAIT
- WAIT:
  - imem_req stays 1 and imem_addr stays constant.
  - On imem_ack=1:
    - instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1
    - imem_req<=0, next state DONE
  - Otherwise timer increments. When timer==TIMEOUT_CYCLES-1 and there is no ack:
    - imem_req<=0, fetch_err<=1, next state ERR
  - An ack on the timeout cycle counts as success; ack wins over timeout.
  - fetch_start is ignored in WAIT.
- DONE and ERR hold all outputs until the next fetch_start or flush.
- imem_ack outside WAIT is ignored.
- Latency:
  - fetch_start sampled at edge 0 → imem_req=1 in cycle 1.
  - imem_ack sampled at edge k (k≥1) → instr_valid=1 in cycle k+1.
  - Zero-wait memory (ack in cycle 1) gives instr_valid in cycle 2.
- flush=1 in any state:
  - Next state IDLE, imem_req<=0, instr_valid<=0, fetch_err<=0.
  - instr<=RESET_INSTR; instr_pc is retained.
  - flush has priority over fetch_start and imem_ack in the same cycle.
  - A memory still completing a flushed request must tolerate the req drop.
- busy = (state==WAIT).
- Reset mid-WAIT: imem_req drops immediately (asynchronous); no data is latched.
- Timer width is 8 bits; it never wraps because timeout ends WAIT first.

Optional Feature:
- Macro: IFETCH_ALIGN_CHECK_EN.
- Defined: fetch_start with pc_addr[1:0]!=0 issues no request.
  - Next state ERR directly, fetch_err<=1.
  - instr_pc<=pc_addr to record the faulting PC.
  - instr_valid<=0, imem_req stays 0.
- Undefined: imem_addr<={pc_addr[WIDTH-1:2],2'b00}. Misalignment is silently truncated and no error is raised.

Decomposition:
- Package ifetch_pkg contains:
  - state enum: IDLE=2'd0, WAIT=2'd1, DONE=2'd2, ERR=2'd3
  - IFETCH_RESET_ADDR=32'h0000_3000
  - IFETCH_NOP=32'h0000_0000
- Sub-module fetch_timeout_ctr: 8-bit counter with clear, enable and a terminal-count compare against TIMEOUT_CYCLES-1. It has the same clk/rst as the parent.

Test Plan:
- Reset release, no stimulus → imem_req=0, imem_addr=instr_pc=0x3000, instr=0, instr_valid=0, fetch_err=0.
- pc_addr=0x3004, fetch_start cycle 0, ack cycle 1 with rdata=0x2408_0005 → imem_req=1 in cycle 1 only; instr=0x24080005, instr_pc=0x3004, instr_valid=1 from cycle 2.
- Ack delayed to cycle 6, with fetch_start re-pulsed in cycle 3 → imem_addr stable for cycles 1–6; the second start is ignored; instr_valid=1 in cycle 7.
- No ack, TIMEOUT_CYCLES=15 → imem_req high cycles 1–15, fetch_err=1 and imem_req=0 from cycle 16. Variant with ack in cycle 15 → success, fetch_err=0.
- flush and imem_ack in the same WAIT cycle → IDLE, instr=0, instr_valid=0. A following fetch_start of 0x3008 completes normally.
- With IFETCH_ALIGN_CHECK_EN, fetch_start with pc_addr=0x3006 → imem_req never rises; fetch_err=1 and instr_pc=0x3006 next cycle. Without the macro → imem_addr=0x3004.
